// File: rtl/ldst_pkg.sv
// Shared definitions for the load/store coalescing engine: FSM encoding and
// segment/word offset geometry helpers.
package ldst_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        WB       = 2'd3
    } ldstState_e;

    function automatic int segOffW(input int segBytes);
        return $clog2(segBytes);
    endfunction

    function automatic int wordOffW(input int segBytes, input int dataW);
        return $clog2(segBytes) - $clog2(dataW / 8);
    endfunction

    localparam int SEG_BYTES_DEF = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int SEG_OFF_W     = segOffW(SEG_BYTES_DEF);
    localparam int WORD_OFF_W    = wordOffW(SEG_BYTES_DEF, DATA_W_DEF);
    localparam int WORDS_PER_SEG = 1 << WORD_OFF_W;

endpackage

// File: rtl/ldst_seg_match.sv
// Picks the lowest pending lane as leader and reports which pending lanes
// fall into the leader's aligned segment.
module ldst_seg_match
    import ldst_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int ADDR_W    = 32,
    parameter int SEG_BYTES = 32
) (
    input  logic [NUM_LANES-1:0]        pending,
    input  logic [NUM_LANES*ADDR_W-1:0] laneAddr,
    output logic [ADDR_W-1:0]           segBase,
    output logic [NUM_LANES-1:0]        matchMask
);

    localparam int SOW    = segOffW(SEG_BYTES);
    localparam int LIDX_W = $clog2(NUM_LANES);

    logic [LIDX_W-1:0] leaderIdx_s;

    // Leader selection, segment base and membership of every pending lane
    always_comb begin
        leaderIdx_s = '0;
        matchMask   = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            leaderIdx_s = pending[l] ? LIDX_W'(l) : leaderIdx_s;
        end
        segBase = laneAddr[leaderIdx_s*ADDR_W +: ADDR_W] & ~ADDR_W'(SEG_BYTES - 1);
        for (int l = 0; l < NUM_LANES; l++) begin
            matchMask[l] = pending[l] &&
                (laneAddr[l*ADDR_W+SOW +: ADDR_W-SOW] == segBase[ADDR_W-1:SOW]);
        end
    end

endmodule

// File: rtl/ldst_coalesce_engine.sv
// Splits one warp-wide load/store into per-segment memory transactions and
// reassembles load responses into a single per-lane writeback packet.
module ldst_coalesce_engine
    import ldst_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int WARP_W    = 3,
    parameter int SEG_BYTES = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_store_i,
    input  logic [WARP_W-1:0]             req_warp_i,
    input  logic [NUM_LANES-1:0]          req_mask_i,
    input  logic [REG_W-1:0]              req_reg_i,
    input  logic [NUM_LANES*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_LANES*DATA_W-1:0]   req_data_i,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic                          mem_req_we_o,
    output logic [ADDR_W-1:0]             mem_req_addr_o,
    output logic [SEG_BYTES*8-1:0]        mem_req_wdata_o,
    output logic [SEG_BYTES-1:0]          mem_req_be_o,
    input  logic                          mem_rsp_valid_i,
    input  logic [SEG_BYTES*8-1:0]        mem_rsp_data_i,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [WARP_W-1:0]             wb_warp_o,
    output logic [NUM_LANES-1:0]          wb_mask_o,
    output logic [REG_W-1:0]              wb_reg_o,
    output logic [NUM_LANES*DATA_W-1:0]   wb_data_o,
    output logic                          busy_o,
    output logic [$clog2(NUM_LANES+1)-1:0] seg_count_o
);

    localparam int BPW        = DATA_W / 8;
    localparam int BYTE_OFF_W = $clog2(BPW);
    localparam int WOW        = wordOffW(SEG_BYTES, DATA_W);
    localparam int WPS        = 1 << WOW;
    localparam int CNT_W      = $clog2(NUM_LANES + 1);

    ldstState_e                  state_r, nextState_s;
    logic                        store_r;
    logic [WARP_W-1:0]           warp_r;
    logic [NUM_LANES-1:0]        mask_r, pending_r, match_r, match_s;
    logic [REG_W-1:0]            dstReg_r;
    logic [NUM_LANES*ADDR_W-1:0] addr_r;
    logic [NUM_LANES*DATA_W-1:0] data_r;
    logic [CNT_W-1:0]            segCount_r;
    logic [ADDR_W-1:0]           segBase_s;
    logic [SEG_BYTES*8-1:0]      wdata_s;
    logic [SEG_BYTES-1:0]        be_s;
    logic                        inIssue_s, inWb_s;

    ldst_seg_match #(
        .NUM_LANES (NUM_LANES),
        .ADDR_W    (ADDR_W),
        .SEG_BYTES (SEG_BYTES)
    ) u_segMatch (
        .pending   (pending_r),
        .laneAddr  (addr_r),
        .segBase   (segBase_s),
        .matchMask (match_s)
    );

    // Store merge: ascending lane order lets the highest lane win a shared word
    always_comb begin
        wdata_s = '0;
        be_s    = '0;
        for (int w = 0; w < WPS; w++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (match_s[l] && (addr_r[l*ADDR_W+BYTE_OFF_W +: WOW] == WOW'(w))) begin
                    wdata_s[w*DATA_W +: DATA_W] = data_r[l*DATA_W +: DATA_W];
                    be_s[w*BPW +: BPW]          = {BPW{1'b1}};
                end else begin
                    wdata_s = wdata_s;
                    be_s    = be_s;
                end
            end
        end
    end

    // Next-state decode
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid_i && (req_mask_i != '0)) nextState_s = ISSUE;
                else                                   nextState_s = IDLE;
            end
            ISSUE: begin
                if (!mem_req_ready_i)                          nextState_s = ISSUE;
                else if (!store_r)                             nextState_s = WAIT_RSP;
                else if ((pending_r & ~match_s) == '0)         nextState_s = IDLE;
                else                                           nextState_s = ISSUE;
            end
            WAIT_RSP: begin
                if (!mem_rsp_valid_i)                          nextState_s = WAIT_RSP;
                else if ((pending_r & ~match_r) == '0)         nextState_s = WB;
                else                                           nextState_s = ISSUE;
            end
            WB: begin
                if (wb_ready_i) nextState_s = IDLE;
                else            nextState_s = WB;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= nextState_s;
    end

    // Request latch, pending bookkeeping and load scatter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_r    <= 1'b0;
            warp_r     <= '0;
            mask_r     <= '0;
            dstReg_r   <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            pending_r  <= '0;
            match_r    <= '0;
            segCount_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid_i) begin
                        store_r    <= req_store_i;
                        warp_r     <= req_warp_i;
                        mask_r     <= req_mask_i;
                        dstReg_r   <= req_reg_i;
                        addr_r     <= req_addr_i;
                        data_r     <= req_store_i ? req_data_i : '0;
                        pending_r  <= req_mask_i;
                        match_r    <= '0;
                        segCount_r <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        segCount_r <= segCount_r + CNT_W'(1);
                        if (store_r) pending_r <= pending_r & ~match_s;
                        else         match_r   <= match_s;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid_i) begin
                        pending_r <= pending_r & ~match_r;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (match_r[l]) begin
                                data_r[l*DATA_W +: DATA_W] <=
                                    mem_rsp_data_i[addr_r[l*ADDR_W+BYTE_OFF_W +: WOW]*DATA_W +: DATA_W];
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign inIssue_s       = (state_r == ISSUE);
    assign inWb_s          = (state_r == WB);
    assign req_ready_o     = (state_r == IDLE);
    assign busy_o          = (state_r != IDLE);
    assign seg_count_o     = segCount_r;
    assign mem_req_valid_o = inIssue_s;
    assign mem_req_we_o    = inIssue_s & store_r;
    assign mem_req_addr_o  = inIssue_s ? segBase_s : '0;
    assign mem_req_wdata_o = (inIssue_s && store_r) ? wdata_s : '0;
    assign mem_req_be_o    = (inIssue_s && store_r) ? be_s : '0;
    assign wb_valid_o      = inWb_s;
    assign wb_warp_o       = inWb_s ? warp_r : '0;
    assign wb_mask_o       = inWb_s ? mask_r : '0;
    assign wb_reg_o        = inWb_s ? dstReg_r : '0;
    assign wb_data_o       = inWb_s ? data_r : '0;

endmodule
